instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
MIPS instruction-fetch (IF) stage with the IF/ID pipeline register. It sits directly upstream of the instruction-decode pipeline, whose input is instruction32. It owns the PC, issues single-outstanding requests to a variable-latency instruction memory, and absorbs decode stalls with a one-entry hold buffer. It accepts branch/jump redirects from downstream and squashes wrong-path fetches.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.
PC_STEP, 4, sequential PC increment in bytes.

Ports:
clk  input  1  stage clock, rising-edge.
rst_n  input  1  reset, asynchronous, active-low.
imemReq  output  1  one-cycle request pulse to instruction memory.
imemAddr  output  32  fetch address; equals pc and is valid while imemReq=1.
imemValid  input  1  response strobe; exactly one per accepted request; latency 1 cycle or more.
imemData  input  32  instruction word; valid when imemValid=1.
stall  input  1  hazard unit: hold IF/ID contents.
redirect  input  1  branch/jump taken: flush and refetch.
redirectPc  input  32  target PC; sampled when redirect=1.
ifIdValid  output  1  IF/ID holds a real instruction (0 = bubble).
ifIdInstr  output  32  IF/ID instruction, feeding decode instruction32.
ifIdPc  output  32  PC of ifIdInstr.
ifIdPcPlus4  output  32  ifIdPc + PC_STEP.

Behaviour:
- Reset (rst_n=0, asynchronous): pc=RESET_PC, state=ISSUE, hold buffer empty. ifIdValid=0, ifIdInstr=0, ifIdPc=0, ifIdPcPlus4=0. imemReq=0 while reset is asserted.
- FSM states: ISSUE, WAIT, HOLD, SQUASH. At most one request is outstanding.
- ISSUE:
  - imemReq = !redirect; imemAddr = pc.
  - If redirect: pc <= redirectPc and state stays ISSUE.
  - Otherwise: go to WAIT.
- WAIT (imemReq=0):
  - redirect and imemValid in the same cycle: drop the data, pc <= redirectPc, go to ISSUE.
  - redirect without imemValid: pc <= redirectPc, go to SQUASH.
  - imemValid and !stall: load IF/ID with {1, imemData, pc, pc+PC_STEP}, pc <= pc+PC_STEP, go to ISSUE.
  - imemValid and stall: capture imemData in the hold buffer, go to HOLD.
- HOLD:
  - redirect: discard the buffer, pc <= redirectPc, go to ISSUE.
  - !stall: load IF/ID from the buffer, pc <= pc+PC_STEP, go to ISSUE.
  - Otherwise: stay in HOLD.
- SQUASH:
  - Wait for imemValid, then discard the data and go to ISSUE.
  - A further redirect updates pc and the state stays SQUASH.
  - A redirect coinciding with imemValid updates pc and goes to ISSUE.
- IF/ID update rules, applied each cycle in priority order:
  1. redirect: ifIdValid <= 0 (flush). This wins over stall.
  2. stall: all IF/ID registers hold.
  3. New instruction available (WAIT+imemValid, or leaving HOLD): load it.
  4. Otherwise: ifIdValid <= 0 (bubble). ifIdInstr, ifIdPc and ifIdPcPlus4 hold their last values.
- Throughput: with 1-cycle memory latency and no stall, one instruction every 2 cycles.
- Arithmetic: pc is 32 bits and wraps modulo 2^32 (32'hFFFFFFFC + 4 = 0). The low 2 bits of redirectPc pass through unchanged; alignment is not checked.
- Reset mid-request: an outstanding response that arrives after reset deasserts is treated as a new response only if the state is WAIT. Because the state is ISSUE after reset, the memory model must also be reset with the same rst_n.

Decomposition:
- Shared package (mips_pkg):
  - FSM state encoding (ISSUE=2'd0, WAIT=2'd1, HOLD=2'd2, SQUASH=2'd3).
  - RESET_PC default.
  - INSTR_WIDTH=32.
- Sub-module if_id_reg: IF/ID register with load, flush and hold controls, reusable for later ID/EX work.
- The PC, FSM and hold buffer stay in instruction_fetch.

Test Plan:
1. Reset, then a 1-cycle memory returning 32'h20080005 at 0, 32'h20090007 at 4 -> imemAddr sequence 0,4,8. ifIdInstr=20080005 with ifIdPc=0 and ifIdPcPlus4=4, then 20090007 with ifIdPc=4. ifIdValid pulses every 2nd cycle.
2. stall=1 for 3 cycles while the response for address 8 arrives -> IF/ID holds the previous instruction. State goes to HOLD and no new imemReq is issued. One cycle after stall drops, ifIdPc=8 and the next imemAddr=12.
3. 3-cycle memory latency; redirect=1 with redirectPc=32'h00000100 during WAIT -> the late response is discarded and ifIdValid stays 0. The next imemReq has imemAddr=100, and ifIdPc=100 follows.
4. redirect and stall both asserted in HOLD -> ifIdValid=0 the next cycle, the buffer is dropped, and the next imemAddr=redirectPc.
5. redirect in the same cycle as imemValid in WAIT -> data is dropped, no SQUASH, and the next cycle is ISSUE at redirectPc.
6. redirectPc=32'hFFFFFFFC followed by a sequential fetch -> the instruction at FFFFFFFC has ifIdPcPlus4=0, and the next imemAddr=0. Then assert rst_n=0 asynchronously mid-WAIT -> all outputs go to 0 immediately, and imemAddr=RESET_PC after release.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end: fetch FSM encoding,
// reset vector default and instruction width.
package mips_pkg;

    localparam int          INSTR_WIDTH      = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_ISSUE  = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HOLD   = 2'd2,
        ST_SQUASH = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register between fetch and decode. Flush beats hold, hold beats load,
// and an idle cycle inserts a bubble while keeping the payload fields.
module if_id_reg
    import mips_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_load,
    input  logic                   i_flush,
    input  logic                   i_hold,
    input  logic [INSTR_WIDTH-1:0] i_instr,
    input  logic [31:0]            i_pc,
    input  logic [31:0]            i_pc_plus4,
    output logic                   o_valid,
    output logic [INSTR_WIDTH-1:0] o_instr,
    output logic [31:0]            o_pc,
    output logic [31:0]            o_pc_plus4
);

    logic                   r_valid;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic [31:0]            r_pc;
    logic [31:0]            r_pc_plus4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_instr    <= '0;
            r_pc       <= '0;
            r_pc_plus4 <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_hold) begin
            r_valid <= r_valid;
        end else if (i_load) begin
            r_valid    <= 1'b1;
            r_instr    <= i_instr;
            r_pc       <= i_pc;
            r_pc_plus4 <= i_pc_plus4;
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid    = r_valid;
    assign o_instr    = r_instr;
    assign o_pc       = r_pc;
    assign o_pc_plus4 = r_pc_plus4;

endmodule

// File: rtl/instruction_fetch.sv
// MIPS IF stage: owns the PC, keeps at most one instruction-memory request in
// flight, parks a response in a hold buffer during decode stalls, and squashes wrong-path fetches.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   imemReq,
    output logic [31:0]            imemAddr,
    input  logic                   imemValid,
    input  logic [INSTR_WIDTH-1:0] imemData,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [31:0]            redirectPc,
    output logic                   ifIdValid,
    output logic [INSTR_WIDTH-1:0] ifIdInstr,
    output logic [31:0]            ifIdPc,
    output logic [31:0]            ifIdPcPlus4
);

    fetch_state_t           r_state;
    logic [31:0]            r_pc;
    logic [INSTR_WIDTH-1:0] r_hold_data;

    logic [31:0]            w_pc_seq;
    logic                   w_new_instr;
    logic [INSTR_WIDTH-1:0] w_new_data;

    assign w_pc_seq    = r_pc + PC_STEP;
    assign w_new_instr = ((r_state == ST_WAIT) && imemValid) || (r_state == ST_HOLD);
    assign w_new_data  = (r_state == ST_HOLD) ? r_hold_data : imemData;

    // State comes up as ISSUE during reset, so the request is gated by rst_n itself.
    assign imemReq  = rst_n && (r_state == ST_ISSUE) && !redirect;
    assign imemAddr = r_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_ISSUE;
            r_pc        <= RESET_PC;
            r_hold_data <= '0;
        end else begin
            case (r_state)
                ST_ISSUE: begin
                    if (redirect) r_pc <= redirectPc;
                    else          r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (redirect) begin
                        r_pc    <= redirectPc;
                        r_state <= imemValid ? ST_ISSUE : ST_SQUASH;
                    end else if (imemValid) begin
                        if (stall) begin
                            r_hold_data <= imemData;
                            r_state     <= ST_HOLD;
                        end else begin
                            r_pc    <= w_pc_seq;
                            r_state <= ST_ISSUE;
                        end
                    end
                end
                ST_HOLD: begin
                    if (redirect) begin
                        r_pc    <= redirectPc;
                        r_state <= ST_ISSUE;
                    end else if (!stall) begin
                        r_pc    <= w_pc_seq;
                        r_state <= ST_ISSUE;
                    end
                end
                default: begin
                    // Wrong-path response still owed by memory: swallow it.
                    if (redirect)  r_pc    <= redirectPc;
                    if (imemValid) r_state <= ST_ISSUE;
                end
            endcase
        end
    end

    if_id_reg u_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_new_instr),
        .i_flush    (redirect),
        .i_hold     (stall),
        .i_instr    (w_new_data),
        .i_pc       (r_pc),
        .i_pc_plus4 (w_pc_seq),
        .o_valid    (ifIdValid),
        .o_instr    (ifIdInstr),
        .o_pc       (ifIdPc),
        .o_pc_plus4 (ifIdPcPlus4)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a variable-latency memory model and
// a program-order fetch model checked every cycle.
module tb_instruction_fetch;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        stall      = 1'b0;
    logic        redirect   = 1'b0;
    logic [31:0] redirectPc = 32'h0;
    logic        imemValid  = 1'b0;
    logic [31:0] imemData   = 32'h0;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        ifIdValid;
    logic [31:0] ifIdInstr;
    logic [31:0] ifIdPc;
    logic [31:0] ifIdPcPlus4;

    int n_vec = 0;
    int n_err = 0;

    instruction_fetch #(.RESET_PC(32'h0), .PC_STEP(32'd4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imemReq     (imemReq),
        .imemAddr    (imemAddr),
        .imemValid   (imemValid),
        .imemData    (imemData),
        .stall       (stall),
        .redirect    (redirect),
        .redirectPc  (redirectPc),
        .ifIdValid   (ifIdValid),
        .ifIdInstr   (ifIdInstr),
        .ifIdPc      (ifIdPc),
        .ifIdPcPlus4 (ifIdPcPlus4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0)      return 32'h2008_0005;
        else if (a == 32'h4) return 32'h2009_0007;
        else                 return a ^ 32'h3C00_A5A5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory: a request seen mid-cycle is answered after lat edges, one-cycle strobe.
    int          lat = 1;
    bit          mem_pend = 0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = 32'h0;
    bit          req_seen = 0;
    logic [31:0] req_seen_addr = 32'h0;

    always @(negedge clk) begin
        req_seen      = imemReq;
        req_seen_addr = imemAddr;
    end

    always @(posedge clk) begin
        #1;
        imemValid = 1'b0;
        if (!rst_n) begin
            mem_pend = 0;
        end else begin
            if (mem_pend) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    imemValid = 1'b1;
                    imemData  = mem_word(mem_addr);
                    mem_pend  = 0;
                end
            end
            if (req_seen) begin
                if (lat <= 1) begin
                    imemValid = 1'b1;
                    imemData  = mem_word(req_seen_addr);
                end else begin
                    mem_pend = 1;
                    mem_cnt  = lat - 1;
                    mem_addr = req_seen_addr;
                end
            end
        end
    end

    // Program-order model: next fetch address, whether a live request exists for it,
    // and the IF/ID rules (flush / hold / new instruction / bubble).
    logic [31:0] exp_pc = 32'h0;
    bit          req_made = 0;
    bit          c_stall = 0;
    bit          c_redirect = 0;
    logic        p_valid = 1'b0;
    logic [31:0] p_instr = 32'h0, p_pc = 32'h0, p_pcp4 = 32'h0;
    int          cyc = 0;
    int          deliv_cnt = 0;
    int          req_cnt = 0;
    logic [31:0] deliv_pc[$];
    int          deliv_cyc[$];

    initial begin
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (!rst_n) begin
                chk("rst_valid", 32'(ifIdValid), 32'h0);
                chk("rst_instr", ifIdInstr, 32'h0);
                chk("rst_pc",    ifIdPc, 32'h0);
                chk("rst_pcp4",  ifIdPcPlus4, 32'h0);
                exp_pc = 32'h0; req_made = 0; c_stall = 0; c_redirect = 0;
            end else if (c_redirect) begin
                chk("flush_valid", 32'(ifIdValid), 32'h0);
            end else if (c_stall) begin
                chk("stall_valid", 32'(ifIdValid), 32'(p_valid));
                chk("stall_instr", ifIdInstr, p_instr);
                chk("stall_pc",    ifIdPc, p_pc);
                chk("stall_pcp4",  ifIdPcPlus4, p_pcp4);
            end else if (ifIdValid) begin
                chk("deliv_pc",    ifIdPc, exp_pc);
                chk("deliv_req",   32'(req_made), 32'h1);
                chk("deliv_instr", ifIdInstr, mem_word(exp_pc));
                chk("deliv_pcp4",  ifIdPcPlus4, exp_pc + 32'd4);
                $display("deliver #%0d cycle %0d pc=%h instr=%h", deliv_cnt, cyc, ifIdPc, ifIdInstr);
                deliv_pc.push_back(ifIdPc);
                deliv_cyc.push_back(cyc);
                deliv_cnt++;
                exp_pc   = exp_pc + 32'd4;
                req_made = 0;
            end else begin
                chk("bubble_instr", ifIdInstr, p_instr);
                chk("bubble_pc",    ifIdPc, p_pc);
                chk("bubble_pcp4",  ifIdPcPlus4, p_pcp4);
            end
            p_valid = ifIdValid; p_instr = ifIdInstr; p_pc = ifIdPc; p_pcp4 = ifIdPcPlus4;

            @(negedge clk);
            if (!rst_n) begin
                chk("rst_req", 32'(imemReq), 32'h0);
                exp_pc = 32'h0; req_made = 0; c_stall = 0; c_redirect = 0;
            end else begin
                if (imemReq) begin
                    chk("req_addr", imemAddr, exp_pc);
                    chk("req_busy", 32'(req_made || mem_pend || imemValid), 32'h0);
                    req_made = 1;
                    req_cnt++;
                end
                if (redirect) begin
                    chk("req_on_redirect", 32'(imemReq), 32'h0);
                    exp_pc   = redirectPc;
                    req_made = 0;
                end
                c_stall    = stall;
                c_redirect = redirect;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic wait_delivery();
        int target = deliv_cnt + 1;
        int n = 0;
        while (deliv_cnt < target && n < 40) begin
            step();
            n++;
        end
        chk("deliv_timeout", 32'(deliv_cnt >= target), 32'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        // Reset
        repeat (3) step();
        chk("t0_valid", 32'(ifIdValid), 32'h0);
        chk("t0_req",   32'(imemReq), 32'h0);
        chk("t0_addr",  imemAddr, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("t0_first_req", 32'(imemReq), 32'h1);

        // 1: sequential fetch, 1-cycle memory
        wait_delivery();
        wait_delivery();
        chk("t1_pc0",   deliv_pc[0], 32'h0);
        chk("t1_pc1",   deliv_pc[1], 32'h4);
        chk("t1_gap",   32'(deliv_cyc[1] - deliv_cyc[0]), 32'd2);
        chk("t1_instr", ifIdInstr, 32'h2009_0007);
        chk("t1_pcp4",  ifIdPcPlus4, 32'h8);
        chk("t1_addr",  imemAddr, 32'h8);

        // 2: stall three cycles across the response for 8
        stall = 1'b1;
        repeat (3) step();
        chk("t2_hold_pc",    ifIdPc, 32'h4);
        chk("t2_hold_valid", 32'(ifIdValid), 32'h1);
        chk("t2_no_req",     32'(imemReq), 32'h0);
        stall = 1'b0;
        step();
        chk("t2_pc",      ifIdPc, 32'h8);
        chk("t2_valid",   32'(ifIdValid), 32'h1);
        chk("t2_addr",    imemAddr, 32'hC);
        chk("t2_req_cnt", 32'(req_cnt), 32'd3);

        // 3: 3-cycle memory, redirect while waiting
        lat = 3;
        d0 = deliv_cnt;
        step();
        redirect = 1'b1; redirectPc = 32'h100;
        step();
        redirect = 1'b0;
        chk("t3_flush", 32'(ifIdValid), 32'h0);
        wait_delivery();
        chk("t3_one_deliv", 32'(deliv_cnt - d0), 32'd1);
        chk("t3_pc",        ifIdPc, 32'h100);
        chk("t3_instr",     ifIdInstr, 32'h3C00_A4A5);

        // 4: redirect and stall together in HOLD
        lat = 1;
        stall = 1'b1;
        d0 = deliv_cnt;
        repeat (2) step();
        redirect = 1'b1; redirectPc = 32'h200;
        step();
        chk("t4_valid", 32'(ifIdValid), 32'h0);
        redirect = 1'b0; stall = 1'b0;
        #1;
        chk("t4_req",   32'(imemReq), 32'h1);
        chk("t4_addr",  imemAddr, 32'h200);
        chk("t4_drop",  32'(deliv_cnt - d0), 32'd0);
        wait_delivery();
        chk("t4_pc", ifIdPc, 32'h200);

        // 5: redirect coinciding with the response
        d0 = deliv_cnt;
        step();
        chk("t5_resp", 32'(imemValid), 32'h1);
        redirect = 1'b1; redirectPc = 32'h300;
        step();
        redirect = 1'b0;
        #1;
        chk("t5_req",  32'(imemReq), 32'h1);
        chk("t5_addr", imemAddr, 32'h300);
        chk("t5_drop", 32'(deliv_cnt - d0), 32'd0);
        wait_delivery();
        chk("t5_pc", ifIdPc, 32'h300);

        // 6: wrap at the top of the address space, then reset mid-WAIT
        redirect = 1'b1; redirectPc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        wait_delivery();
        chk("t6_pc",   ifIdPc, 32'hFFFF_FFFC);
        chk("t6_pcp4", ifIdPcPlus4, 32'h0);
        chk("t6_addr", imemAddr, 32'h0);
        step();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(ifIdValid), 32'h0);
        chk("t6_rst_instr", ifIdInstr, 32'h0);
        chk("t6_rst_pc",    ifIdPc, 32'h0);
        chk("t6_rst_pcp4",  ifIdPcPlus4, 32'h0);
        chk("t6_rst_req",   32'(imemReq), 32'h0);
        chk("t6_rst_addr",  imemAddr, 32'h0);
        repeat (2) step();
        rst_n = 1'b1;
        #1;
        chk("t6_req",  32'(imemReq), 32'h1);
        chk("t6_addr0", imemAddr, 32'h0);
        wait_delivery();
        chk("t6_instr0", ifIdInstr, 32'h2008_0005);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
